// File: rtl/sniffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sniffer_pkg
//  Brief   : Shared FSM states, slot geometry and result header layout
//  Revision: 1.0 - initial release
// ============================================================================
package sniffer_pkg;

  localparam int SLOT_BYTES  = 1550;
  localparam int MAX_PAYLOAD = 1544;

  // Result header word: truncation flag in the MSB, byte count in the low half
  localparam int c_hdr_ovf_bit = 31;
  localparam int c_hdr_cnt_w   = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    FLUSH   = 3'd3,
    HEADER  = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module  : byte_packer
//  Brief   : Little-endian byte-to-word lane register with byte-enable mask
//  Revision: 1.0 - initial release
// ============================================================================
module byte_packer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        we,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  input  logic [1:0]  fill,
  output logic [31:0] word_nxt,
  output logic [3:0]  byteen
);

  logic [31:0] word_q;

  // Lane 0 starts a fresh word, so stale upper lanes never leak into a partial write
  always_comb begin
    word_nxt = word_q;
    if (we) begin
      if (lane == 2'd0) begin
        word_nxt = {24'd0, din};
      end else begin
        word_nxt[{lane, 3'b000} +: 8] = din;
      end
    end
  end

  always_comb begin
    byteen = 4'hF;
    case (fill)
      2'd1:    byteen = 4'h1;
      2'd2:    byteen = 4'h3;
      2'd3:    byteen = 4'h7;
      default: byteen = 4'hF;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_q <= 32'd0;
    end else begin
      word_q <= word_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_packet_writer.sv
`default_nettype none
// ============================================================================
//  Module  : result_packet_writer
//  Brief   : Packs a byte stream into a result slot, then writes its header
//  Revision: 1.0 - initial release
// ============================================================================
module result_packet_writer #(
  parameter int SLOT_BYTES  = sniffer_pkg::SLOT_BYTES,
  parameter int MAX_PAYLOAD = sniffer_pkg::MAX_PAYLOAD
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] base_addr,
  input  logic        pkt_start,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        pkt_end,
  input  logic        match,
  input  logic        mem_waitrequest,
  output logic        data_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  output logic        mem_write,
  output logic        inc_addr,
  output logic        overflow
);
  import sniffer_pkg::*;

  // Never let the payload spill past the slot even if MAX_PAYLOAD is set too high
  localparam int          c_payload_limit = (MAX_PAYLOAD < SLOT_BYTES - 4) ? MAX_PAYLOAD : SLOT_BYTES - 4;
  localparam logic [15:0] c_limit         = 16'(c_payload_limit);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] base_q, base_d;
  logic        end_q, end_d, match_q, match_d;
  logic        ovf_pkt_q, ovf_pkt_d, overflow_q, overflow_d;
  logic        data_ready_q, data_ready_d, mem_write_q, mem_write_d;
  logic        inc_addr_q, inc_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_byteen_q, mem_byteen_d;

  logic        xfer, start, take, keep, wr_done;
  logic [15:0] cnt_base, cnt_new;
  logic [31:0] base_new, word_nxt, hdr;
  logic [3:0]  pk_byteen;

  assign xfer     = data_valid && data_ready_q;
  assign start    = xfer && pkt_start && (state_q == IDLE || state_q == COLLECT);
  assign take     = start || (xfer && state_q == COLLECT);
  assign cnt_base = start ? 16'd0 : count_q;
  assign keep     = take && (cnt_base < c_limit);
  assign cnt_new  = keep ? cnt_base + 16'd1 : cnt_base;
  assign base_new = start ? base_addr : base_q;
  assign wr_done  = mem_write_q && !mem_waitrequest;

  byte_packer u_packer (
    .clk      (clk),
    .n_rst    (n_rst),
    .we       (keep),
    .lane     (cnt_base[1:0]),
    .din      (data_in),
    .fill     (cnt_new[1:0]),
    .word_nxt (word_nxt),
    .byteen   (pk_byteen)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    base_d       = base_q;
    end_d        = end_q;
    match_d      = match_q;
    ovf_pkt_d    = ovf_pkt_q;
    overflow_d   = overflow_q;
    data_ready_d = data_ready_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_byteen_d = mem_byteen_q;
    mem_write_d  = mem_write_q;
    inc_addr_d   = 1'b0;
    hdr                      = 32'd0;
    hdr[c_hdr_ovf_bit]       = ovf_pkt_q;
    hdr[c_hdr_cnt_w-1:0]     = count_q;

    case (state_q)
      IDLE, COLLECT: begin
        data_ready_d = 1'b1;
        if (take) begin
          base_d    = base_new;
          count_d   = cnt_new;
          end_d     = pkt_end;
          match_d   = match;
          ovf_pkt_d = start ? 1'b0 : ovf_pkt_q;
          if (!keep) begin
            ovf_pkt_d  = 1'b1;
            overflow_d = 1'b1;
          end
          if (keep && cnt_new[1:0] == 2'd0) begin
            state_d      = WRITE;
            data_ready_d = 1'b0;
            mem_write_d  = 1'b1;
            mem_addr_d   = base_new + 32'(cnt_new);
            mem_wdata_d  = word_nxt;
            mem_byteen_d = 4'hF;
          end else if (pkt_end) begin
            state_d      = FLUSH;
            data_ready_d = 1'b0;
            mem_write_d  = (cnt_new[1:0] != 2'd0);
            mem_addr_d   = base_new + 32'd4 + 32'({cnt_new[15:2], 2'b00});
            mem_wdata_d  = word_nxt;
            mem_byteen_d = pk_byteen;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      WRITE: begin
        if (wr_done) begin
          mem_write_d = 1'b0;
          if (end_q) begin
            state_d = FLUSH;
          end else begin
            state_d      = COLLECT;
            data_ready_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!mem_write_q || wr_done) begin
          if (match_q) begin
            state_d      = HEADER;
            mem_write_d  = 1'b1;
            mem_addr_d   = base_q;
            mem_wdata_d  = hdr;
            mem_byteen_d = 4'hF;
          end else begin
            state_d      = IDLE;
            mem_write_d  = 1'b0;
            data_ready_d = 1'b1;
          end
        end
      end
      HEADER: begin
        if (wr_done) begin
          state_d     = DONE;
          mem_write_d = 1'b0;
          inc_addr_d  = 1'b1;
        end
      end
      DONE: begin
        state_d      = IDLE;
        data_ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      count_q      <= 16'd0;
      base_q       <= 32'd0;
      end_q        <= 1'b0;
      match_q      <= 1'b0;
      ovf_pkt_q    <= 1'b0;
      overflow_q   <= 1'b0;
      data_ready_q <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_byteen_q <= 4'd0;
      mem_write_q  <= 1'b0;
      inc_addr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      base_q       <= base_d;
      end_q        <= end_d;
      match_q      <= match_d;
      ovf_pkt_q    <= ovf_pkt_d;
      overflow_q   <= overflow_d;
      data_ready_q <= data_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_byteen_q <= mem_byteen_d;
      mem_write_q  <= mem_write_d;
      inc_addr_q   <= inc_addr_d;
    end
  end

  assign data_ready = data_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_byteen = mem_byteen_q;
  assign mem_write  = mem_write_q;
  assign inc_addr   = inc_addr_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_result_packet_writer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_result_packet_writer
//  Brief   : Directed self-checking bench for result_packet_writer
//  Revision: 1.0 - initial release
// ============================================================================
module tb_result_packet_writer;

  localparam int SLOT = 1550;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [31:0] base_origin = 32'h0000_060E;
  logic [31:0] slot_off = 32'd0;
  logic [31:0] base_addr;
  logic        pkt_start = 1'b0, data_valid = 1'b0, pkt_end = 1'b0, match = 1'b0;
  logic        mem_waitrequest = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        data_ready, mem_write, inc_addr, overflow;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;

  int total = 0;
  int bad   = 0;
  int wr_n  = 0;
  int inc_n = 0;
  logic [31:0] log_addr [0:2047];
  logic [31:0] log_data [0:2047];
  logic [3:0]  log_be   [0:2047];

  result_packet_writer dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .base_addr       (base_addr),
    .pkt_start       (pkt_start),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .pkt_end         (pkt_end),
    .match           (match),
    .mem_waitrequest (mem_waitrequest),
    .data_ready      (data_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_byteen      (mem_byteen),
    .mem_write       (mem_write),
    .inc_addr        (inc_addr),
    .overflow        (overflow)
  );

  assign base_addr = base_origin + slot_off;

  always #5 clk = ~clk;

  // Result address stage: each inc_addr pulse moves to the next slot
  always @(posedge clk) begin
    if (inc_addr) slot_off <= slot_off + 32'(SLOT);
  end

  // Memory side: log every completed write and count header pulses
  always @(negedge clk) begin
    if (mem_write && !mem_waitrequest && wr_n < 2048) begin
      log_addr[wr_n[10:0]] <= mem_addr;
      log_data[wr_n[10:0]] <= mem_wdata;
      log_be[wr_n[10:0]]   <= mem_byteen;
      wr_n <= wr_n + 1;
    end
    if (inc_addr) inc_n <= inc_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    chk({tag, "_addr"}, log_addr[idx[10:0]], a);
    chk({tag, "_data"}, log_data[idx[10:0]], d);
    chk({tag, "_be"}, 32'(log_be[idx[10:0]]), 32'(be));
  endtask

  // Called at posedge+1; holds the byte until the DUT has accepted it
  task automatic send(input logic [7:0] b, input logic s, input logic e, input logic m);
    logic got;
    logic r;
    int   n;
    got = 1'b0;
    n   = 0;
    data_in = b; pkt_start = s; pkt_end = e; match = m; data_valid = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      r = data_ready;
      @(posedge clk);
      #1;
      if (r === 1'b1) got = 1'b1;
      n++;
    end
    data_valid = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0; match = 1'b0;
    chk("send_accept", 32'(got), 32'd1);
  endtask

  task automatic wait_inc(input string tag);
    int n;
    n = 0;
    while (inc_addr !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_inc_seen"}, 32'(inc_addr), 32'd1);
    chk({tag, "_done_rdy"}, 32'(data_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_inc_pulse"}, 32'(inc_addr), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"}, 32'(data_ready), 32'd0);
    chk({tag, "_wr"}, 32'(mem_write), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_be"}, 32'(mem_byteen), 32'd0);
    chk({tag, "_inc"}, 32'(inc_addr), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int w0;
    int i0;
    logic [31:0] b;

    #1 n_rst = 1'b0;
    #3;
    chk_reset_outs("rst");
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);
    #1;

    // 5-byte packet committed
    w0 = wr_n; i0 = inc_n;
    send(8'h11, 1'b1, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b0, 1'b1);
    send(8'h44, 1'b0, 1'b0, 1'b1);
    send(8'h55, 1'b0, 1'b1, 1'b1);
    wait_inc("t1");
    chk("t1_nwr", 32'(wr_n - w0), 32'd3);
    chk("t1_ninc", 32'(inc_n - i0), 32'd1);
    chk_wr("t1_w0", w0,     32'h0000_0612, 32'h4433_2211, 4'hF);
    chk_wr("t1_w1", w0 + 1, 32'h0000_0616, 32'h0000_0055, 4'h1);
    chk_wr("t1_hd", w0 + 2, 32'h0000_060E, 32'h0000_0005, 4'hF);

    // Same packet discarded
    b = base_addr;
    chk("t2_base", b, 32'h0000_0C1C);
    w0 = wr_n; i0 = inc_n;
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("t2_nwr", 32'(wr_n - w0), 32'd2);
    chk("t2_ninc", 32'(inc_n - i0), 32'd0);
    chk("t2_rdy", 32'(data_ready), 32'd1);
    chk_wr("t2_w0", w0,     b + 32'd4, 32'h4433_2211, 4'hF);
    chk_wr("t2_w1", w0 + 1, b + 32'd8, 32'h0000_0055, 4'h1);

    // Three-cycle stall on the first word
    b = base_addr;
    w0 = wr_n; i0 = inc_n;
    send(8'hA1, 1'b1, 1'b0, 1'b1);
    send(8'hA2, 1'b0, 1'b0, 1'b1);
    send(8'hA3, 1'b0, 1'b0, 1'b1);
    mem_waitrequest = 1'b1;
    send(8'hA4, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_wr", 32'(mem_write), 32'd1);
      chk("t3_stall_rdy", 32'(data_ready), 32'd0);
      chk("t3_stall_addr", mem_addr, b + 32'd4);
      chk("t3_stall_data", mem_wdata, 32'hA4A3_A2A1);
      @(posedge clk);
      #1;
    end
    mem_waitrequest = 1'b0;
    send(8'hA5, 1'b0, 1'b1, 1'b1);
    wait_inc("t3");
    chk("t3_nwr", 32'(wr_n - w0), 32'd3);
    chk_wr("t3_w0", w0,     b + 32'd4, 32'hA4A3_A2A1, 4'hF);
    chk_wr("t3_w1", w0 + 1, b + 32'd8, 32'h0000_00A5, 4'h1);
    chk_wr("t3_hd", w0 + 2, b,         32'h0000_0005, 4'hF);

    // 1600-byte packet truncated at 1544
    b = base_addr;
    w0 = wr_n;
    for (int i = 0; i < 1600; i++) begin
      send(8'(i), (i == 0), (i == 1599), 1'b1);
    end
    wait_inc("t4");
    chk("t4_nwr", 32'(wr_n - w0), 32'd387);
    chk_wr("t4_last", w0 + 385, b + 32'd1544, 32'h0706_0504, 4'hF);
    chk_wr("t4_hd",   w0 + 386, b,            32'h8000_0608, 4'hF);
    chk("t4_ovf", 32'(overflow), 32'd1);

    // Stray byte outside a packet, then an exact 4-byte packet
    b = base_addr;
    w0 = wr_n;
    send(8'hEE, 1'b0, 1'b0, 1'b1);
    send(8'h01, 1'b1, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b0, 1'b1);
    send(8'h04, 1'b0, 1'b1, 1'b1);
    wait_inc("t5");
    chk("t5_nwr", 32'(wr_n - w0), 32'd2);
    chk_wr("t5_w0", w0,     b + 32'd4, 32'h0403_0201, 4'hF);
    chk_wr("t5_hd", w0 + 1, b,         32'h0000_0004, 4'hF);
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);

    // Reset while a write is stalled
    mem_waitrequest = 1'b1;
    send(8'hC1, 1'b1, 1'b0, 1'b1);
    send(8'hC2, 1'b0, 1'b0, 1'b1);
    send(8'hC3, 1'b0, 1'b0, 1'b1);
    send(8'hC4, 1'b0, 1'b0, 1'b1);
    chk("t6_pre_wr", 32'(mem_write), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    mem_waitrequest = 1'b0;
    base_origin = 32'h0000_2000 - slot_off;
    w0 = wr_n; i0 = inc_n;
    @(posedge clk);
    #1;
    send(8'hAA, 1'b1, 1'b0, 1'b1);
    send(8'hBB, 1'b0, 1'b1, 1'b1);
    wait_inc("t6");
    chk("t6_nwr", 32'(wr_n - w0), 32'd2);
    chk("t6_ninc", 32'(inc_n - i0), 32'd1);
    chk_wr("t6_w0", w0,     32'h0000_2004, 32'h0000_BBAA, 4'h3);
    chk_wr("t6_hd", w0 + 1, 32'h0000_2000, 32'h0000_0002, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_packet_writer.md
RESULT_PACKET_WRITER -- requirements
Module: result_packet_writer

Interface
REQ-001 SHALL have parameter SLOT_BYTES, default 1550, bytes reserved per result slot.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1544, largest payload byte count stored; word multiple, at most SLOT_BYTES-4.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port base_addr  input  32  current slot base address from result address stage.
REQ-006 SHALL have port pkt_start  input  1  first byte of a packet is on data_in this cycle.
REQ-007 SHALL have port data_in  input  8  packet byte.
REQ-008 SHALL have port data_valid  input  1  data_in is valid; a byte transfers when data_valid and data_ready are both 1.
REQ-009 SHALL have port pkt_end  input  1  qualifies the last byte of a packet.
REQ-010 SHALL have port match  input  1  sampled with pkt_end; 1 means commit the packet, 0 means discard it.
REQ-011 SHALL have port mem_waitrequest  input  1  memory stall; a write completes on a cycle where mem_write=1 and mem_waitrequest=0.
REQ-012 SHALL have port data_ready  output  1  byte accept.
REQ-013 SHALL have port mem_addr  output  32  byte address, word aligned.
REQ-014 SHALL have port mem_wdata  output  32  write data, little-endian byte packing.
REQ-015 SHALL have port mem_byteen  output  4  byte enables.
REQ-016 SHALL have port mem_write  output  1  write request.
REQ-017 SHALL have port inc_addr  output  1  one-cycle pulse that advances the result address stage.
REQ-018 SHALL have port overflow  output  1  sticky; set when a packet is truncated.

Function
REQ-019 SHALL implement states IDLE, COLLECT, WRITE, FLUSH, HEADER, DONE.
REQ-020 IDLE: data_ready=1; a transfer with pkt_start=1 latches base_addr, clears the byte count and the word buffer, stores the byte in lane 0, and goes to COLLECT (or to FLUSH if pkt_end is also 1).
REQ-021 COLLECT: each transfer stores the byte in lane count[1:0] and increments count; filling lane 3 goes to WRITE.
REQ-022 WRITE: mem_addr=base+4+word_offset, mem_byteen=4'hF, data_ready=0; addr/data/byteen SHALL stay stable while mem_waitrequest=1.
REQ-023 On completion of a WRITE, the next state SHALL be FLUSH if pkt_end was seen, otherwise COLLECT.
REQ-024 pkt_end on a transfer that leaves a partial word: FLUSH SHALL write the partial word, with byteen set for the filled lanes only (e.g. 2 bytes -> 4'h3).
REQ-025 pkt_end with the word already written (count%4==0): FLUSH SHALL issue no write.
REQ-026 After FLUSH, match=1 goes to HEADER; match=0 goes to IDLE with no header write and no inc_addr.
REQ-027 HEADER: SHALL write mem_addr=base, mem_wdata={overflow_this_pkt,15'b0,count[15:0]}, byteen=4'hF; then go to DONE.
REQ-028 DONE: SHALL pulse inc_addr for exactly one cycle with data_ready=0, then go to IDLE; the base_addr sampled in IDLE after DONE SHALL be the updated slot.
REQ-029 Bytes beyond MAX_PAYLOAD SHALL be accepted and dropped, with count saturating at MAX_PAYLOAD; SHALL set overflow and overflow_this_pkt.
REQ-030 pkt_start in COLLECT SHALL abort the current packet (no header, no inc_addr) and restart per REQ-020.
REQ-031 Transfers in IDLE without pkt_start SHALL be accepted and dropped.
REQ-032 mem_write SHALL be 1 only in WRITE, in FLUSH with a partial word, and in HEADER.
REQ-033 Outputs SHALL be registered; the first write request appears 1 cycle after the 4th byte transfers.

Reset
REQ-034 While n_rst=0: state=IDLE, data_ready=0, mem_addr=0, mem_wdata=0, mem_byteen=0, mem_write=0, inc_addr=0, overflow=0, count=0.
REQ-035 Reset mid-write SHALL drop mem_write immediately; the partial packet is lost and no inc_addr is issued.

Structure
REQ-036 The state enum, SLOT_BYTES, MAX_PAYLOAD and the header bit positions SHALL live in a shared package, sniffer_pkg.
REQ-037 Byte-to-word packing (lane register, byteen generation) SHALL be one sub-module, byte_packer.

Verification
REQ-038 base=0x060E, bytes 11,22,33,44,55 with pkt_end on 55, match=1 -> writes 0x44332211@0x0612 be F, 0x00000055@0x0616 be 1, 0x00000005@0x060E, then one inc_addr pulse.
REQ-039 Same packet with match=0 -> two data writes, no header write, no inc_addr.
REQ-040 mem_waitrequest=1 for 3 cycles on the first word -> data_ready=0 and mem_addr/data stable, no byte loss.
REQ-041 A 1600-byte packet -> header count=1544, header bit31=1, overflow=1, last data write at base+4+1540.
REQ-042 4-byte packet -> exactly one data write with be F, no FLUSH write, header count=4.
REQ-043 n_rst asserted during a WRITE stall -> all outputs 0 asynchronously; the next packet after reset writes at the new base+4.
